// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  // Bit-counter width; a 1-bit build still needs one counter bit.
  function automatic int cnt_width(input int w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/fa_cell.sv
// Combinational 1-bit full adder from two half adders plus an OR for carry.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic s0, c0, c1;

  half_adder u_ha0 (.a(a),  .b(b),  .s(s0), .c(c0));
  half_adder u_ha1 (.a(s0), .b(ci), .s(s),  .c(c1));

  assign co = c0 | c1;
endmodule

// File: rtl/half_adder.sv
// 1-bit half adder, building block for fa_cell.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: sequences one fa_cell over WIDTH cycles, LSB first,
// with valid/ready handshakes on the request and result sides.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start_valid,
  output logic             o_start_ready,
  input  logic [WIDTH-1:0] i_operand_a,
  input  logic [WIDTH-1:0] i_operand_b,
  input  logic             i_carry_in,
  output logic             o_result_valid,
  input  logic             i_result_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry_out,
  output logic             o_busy
);
  localparam int CW = cnt_width(WIDTH);

  state_e           state;
  logic [WIDTH-1:0] a_sr, b_sr, sum_sr, sum_q, sum_nxt;
  logic [CW-1:0]    cnt;
  logic             carry, cout_q, vld_q, busy_q;
  logic             s, c;

  fa_cell u_fa (.a(a_sr[0]), .b(b_sr[0]), .ci(carry), .s(s), .co(c));

  // Shift form keeps this legal for WIDTH=1, where no upper slice exists.
  assign sum_nxt = (sum_sr >> 1) | (WIDTH'(s) << (WIDTH - 1));

  assign o_start_ready  = (state == IDLE);
  assign o_result_valid = vld_q;
  assign o_sum          = sum_q;
  assign o_carry_out    = cout_q;
  assign o_busy         = busy_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      sum_q  <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      vld_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (i_start_valid) begin
          a_sr   <= i_operand_a;
          b_sr   <= i_operand_b;
          carry  <= i_carry_in;
          sum_sr <= '0;
          cnt    <= '0;
          busy_q <= 1'b1;
          state  <= RUN;
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          sum_sr <= sum_nxt;
          carry  <= c;
          cnt    <= cnt + 1'b1;
          // Result register tracks the last completed sum through IDLE/RUN.
          if (cnt == CW'(WIDTH - 1)) begin
            sum_q  <= sum_nxt;
            cout_q <= c;
            vld_q  <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: if (i_result_ready) begin
          vld_q  <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at WIDTH=8, plus WIDTH=1 and WIDTH=16 builds.
module tb_serial_adder_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // WIDTH=8 instance
  logic       sv8 = 0, rr8 = 1, ci8 = 0;
  logic [7:0] a8 = 0, b8 = 0;
  logic       rdy8, rv8, co8, busy8;
  logic [7:0] sum8;

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start_valid(sv8), .o_start_ready(rdy8),
    .i_operand_a(a8), .i_operand_b(b8), .i_carry_in(ci8), .o_result_valid(rv8),
    .i_result_ready(rr8), .o_sum(sum8), .o_carry_out(co8), .o_busy(busy8));

  // WIDTH=1 instance
  logic sv1 = 0, rr1 = 1, ci1 = 0, a1 = 0, b1 = 0;
  logic rdy1, rv1, co1, busy1, sum1;

  serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start_valid(sv1), .o_start_ready(rdy1),
    .i_operand_a(a1), .i_operand_b(b1), .i_carry_in(ci1), .o_result_valid(rv1),
    .i_result_ready(rr1), .o_sum(sum1), .o_carry_out(co1), .o_busy(busy1));

  // WIDTH=16 instance
  logic        sv16 = 0, rr16 = 1, ci16 = 0;
  logic [15:0] a16 = 0, b16 = 0;
  logic        rdy16, rv16, co16, busy16;
  logic [15:0] sum16;

  serial_adder_ctrl #(.WIDTH(16)) u_dut16 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start_valid(sv16), .o_start_ready(rdy16),
    .i_operand_a(a16), .i_operand_b(b16), .i_carry_in(ci16), .o_result_valid(rv16),
    .i_result_ready(rr16), .o_sum(sum16), .o_carry_out(co16), .o_busy(busy16));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Waits at negedges for rv8; returns edges elapsed since the start handshake.
  task automatic wait_rv8(output int n);
    n = 0;
    while (!rv8 && n < 40) begin @(negedge clk); n++; end
  endtask

  // One full op with ready held high; checks latency, result and return to IDLE.
  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic cin, input logic [7:0] es, input logic ec);
    int n;
    @(negedge clk);
    sv8 = 1; a8 = a; b8 = b; ci8 = cin; rr8 = 1;
    chk({tag, "_rdy"}, 32'(rdy8), 32'(1));
    @(negedge clk);
    sv8 = 0;
    wait_rv8(n);
    chk({tag, "_lat"}, 32'(n), 32'(8));
    chk({tag, "_sum"}, 32'(sum8), 32'(es));
    chk({tag, "_co"},  32'(co8),  32'(ec));
    @(negedge clk);
    chk({tag, "_idle"}, 32'({rv8, rdy8, busy8, sum8}), 32'({3'b010, es}));
  endtask

  initial begin
    int n;
    logic [16:0] ref16;

    repeat (2) @(negedge clk);
    chk("rst_rdy",  32'(rdy8),  32'(1));
    chk("rst_vld",  32'(rv8),   32'(0));
    chk("rst_sum",  32'(sum8),  32'(0));
    chk("rst_co",   32'(co8),   32'(0));
    chk("rst_busy", 32'(busy8), 32'(0));
    rst_n = 1;

    run8("v5a33", 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0);
    run8("vff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run8("vffff", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    run8("v0001", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0);
    run8("v8080", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);

    // Backpressure: hold DONE for 5 cycles, then a one-cycle ready pulse.
    @(negedge clk);
    sv8 = 1; a8 = 8'h12; b8 = 8'h34; ci8 = 0; rr8 = 0;
    @(negedge clk);
    sv8 = 0;
    wait_rv8(n);
    chk("bp_lat", 32'(n), 32'(8));
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", 32'({rv8, busy8, co8, sum8}), 32'({3'b110, 8'h46}));
      @(negedge clk);
    end
    rr8 = 1;
    @(negedge clk);
    rr8 = 0;
    chk("bp_pulse", 32'({rv8, rdy8, busy8}), 32'(3'b010));

    // Requests during RUN/DONE are ignored; the one still pending when DONE is
    // accepted gets taken only once back in IDLE.
    @(negedge clk);
    sv8 = 1; a8 = 8'h0F; b8 = 8'h01; ci8 = 0; rr8 = 0;
    @(negedge clk);
    a8 = 8'hAA; b8 = 8'h55;
    chk("ign_rdy", 32'(rdy8), 32'(0));
    wait_rv8(n);
    chk("ign_lat", 32'(n), 32'(8));
    @(negedge clk);
    chk("ign_sum", 32'({rv8, co8, sum8}), 32'({2'b10, 8'h10}));
    rr8 = 1;
    @(negedge clk);
    chk("ign_idle", 32'({rv8, rdy8, busy8}), 32'(3'b010));
    @(negedge clk);
    sv8 = 0;
    chk("ign_acc", 32'({rdy8, busy8}), 32'(2'b01));
    wait_rv8(n);
    chk("ign2_lat", 32'(n), 32'(8));
    chk("ign2_sum", 32'({co8, sum8}), 32'({1'b0, 8'hFF}));
    @(negedge clk);

    // Reset pulse on the edge that processes bit 3.
    @(negedge clk);
    sv8 = 1; a8 = 8'h11; b8 = 8'h22; ci8 = 0;
    @(negedge clk);
    sv8 = 0;
    repeat (3) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("mrst_state", 32'({rdy8, rv8, busy8, co8, sum8}), 32'({4'b1000, 8'h00}));
    n = 0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); if (rv8) n++; end
    chk("mrst_noresult", 32'(n), 32'(0));
    run8("v1020", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0);

    // WIDTH=1: RUN is a single cycle.
    @(negedge clk);
    sv1 = 1; a1 = 1; b1 = 1; ci1 = 1;
    @(negedge clk);
    sv1 = 0;
    n = 0;
    while (!rv1 && n < 10) begin @(negedge clk); n++; end
    chk("w1_lat", 32'(n), 32'(1));
    chk("w1_res", 32'({co1, sum1}), 32'(2'b11));
    @(negedge clk);
    chk("w1_idle", 32'({rv1, rdy1}), 32'(2'b01));

    // WIDTH=16: random operands against a reference sum.
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      a16 = 16'($urandom); b16 = 16'($urandom); ci16 = 1'($urandom);
      ref16 = 17'(a16) + 17'(b16) + 17'(ci16);
      sv16 = 1;
      @(negedge clk);
      sv16 = 0;
      n = 0;
      while (!rv16 && n < 40) begin @(negedge clk); n++; end
      chk("w16_lat", 32'(n), 32'(16));
      chk("w16_res", 32'({co16, sum16}), 32'(ref16));
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
